reorder_buffer_gen: RTL and testbench
=====================================

// Module: reorder_buffer_gen
// PURPOSE
//  Parametrised in-order-retire reorder buffer; successor to the fixed 16-entry ROB.
//  Sits between IF/decode (issue) and regfile/CDB (commit).
//  Adds: configurable depth and writeback-port count, exact occupancy counter,
//  in-order single-cycle commit, and mispredict flush on commit.
// PARAMETERS
//  DEPTH   16  number of entries (power of two, >=4)
//  IDX_W   4   log2(DEPTH); tag width
//  NUM_WB  3   writeback ports (ALUs + LSB)
//  XLEN    32  data width
// PORTS
//  clk            in   1              clock, rising edge
//  rst            in   1              async, active-high reset
//  rdy            in   1              global enable; 0 = freeze all state
//  issue_valid    in   1              new instruction this cycle
//  issue_ready    out  1              !full (combinational from registered count)
//  issue_tag      out  IDX_W          tag to be assigned (= tail)
//  issue_dest     in   5              rd; x0 allowed
//  issue_kind     in   2              0 normal, 1 branch, 2 jalr, 3 store
//  issue_done     in   1              result known at issue (LUI/JAL/AUIPC/store)
//  issue_value    in   XLEN           result when issue_done=1
//  wb_valid       in   NUM_WB         per-port writeback strobe
//  wb_tag         in   NUM_WB*IDX_W   flattened tags, port p at [p*IDX_W +: IDX_W]
//  wb_value       in   NUM_WB*XLEN    flattened results
//  wb_mispred     in   NUM_WB         branch/jalr resolved wrong
//  wb_target      in   NUM_WB*XLEN    correct PC when wb_mispred=1
//  commit_valid   out  1              one-cycle pulse per retired entry
//  commit_tag     out  IDX_W          retired tag
//  commit_dest    out  5              retired rd
//  commit_value   out  XLEN           retired result
//  commit_kind    out  2              retired kind
//  flush          out  1              one-cycle pulse: pipeline squash
//  flush_pc       out  XLEN           redirect PC, valid with flush
//  count          out  IDX_W+1        occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all entries invalid/not-done;
//    commit_*, flush, flush_pc all 0.
//  - Entry fields: valid, done, mispred, dest, kind, value, target.
//  - Issue:
//    - accepted iff issue_valid & issue_ready & rdy & !flush_next;
//    - writes entry[tail] (done=issue_done, value=issue_value, mispred=0);
//    - tail wraps DEPTH-1 -> 0.
//  - Writeback:
//    - port p with valid entry sets done, value, mispred, target;
//    - wb to an invalid or already-done entry is ignored;
//    - same tag on several ports: lowest port index wins.
//    - Visible for commit the cycle after the wb edge (1-cycle min wb->commit).
//  - Commit: if count!=0 & entry[head].done at posedge:
//    - pulse commit_* next cycle;
//    - clear entry; head++ (wraps).
//    - Max one per cycle.
//  - Count: count_next = count + issued - committed.
//    - Issue+commit same cycle: count unchanged.
//    - Full: issue_ready=0 even if a commit happens that cycle (registered count).
//  - Flush: committing entry with mispred=1 also pulses flush, flush_pc=target.
//    - Same edge: every entry invalidated, head=tail=0, count=0.
//    - Any issue that cycle is dropped; all writebacks that cycle are dropped.
//  - rdy=0: no state change; commit_valid and flush forced 0.
//  - Reset mid-operation: immediate return to reset state; in-flight tags meaningless.
// CONFIGURATION
//  ROB_QUERY_EN defined: adds 2 operand lookup ports.
//    - Inputs q0_tag/q1_tag [IDX_W].
//    - Outputs q0_ready/q1_ready, q0_value/q1_value [XLEN].
//    - Combinational: ready = entry valid & done; also true if a same-cycle
//      wb_valid hits the tag (wb data forwarded, lowest port wins).
//  Undefined: ports absent; dispatch waits on CDB only.
// TESTING
//  - Reset, then issue 16 normal entries (DEPTH=16), no wb:
//    count=16, issue_ready=0, 17th issue ignored.
//  - Issue tags 0,1,2; wb tag2=7 then tag0=5 then tag1=6:
//    commits in order tag0/5, tag1/6, tag2/7 on consecutive cycles.
//  - Branch at tag3 wb mispred=1 target=0x1000, tags 4-6 pending:
//    commits tag3 with flush=1, flush_pc=0x1000; next cycle count=0, issue_tag=0.
//  - Full ROB, head done, issue_valid=1 same cycle:
//    commit occurs, no issue, count=15; next cycle issue accepted, count=16.
//  - Ports 0 and 2 both write tag5 (0xA, 0xB):
//    entry value 0xA; wraparound head/tail 15->0 verified with 20 back-to-back ops.
//  - rdy=0 for 3 cycles with done head: no commit, count frozen;
//    rdy=1 resumes with correct commit.

Source files
------------

// File: rtl/reorder_buffer_gen_if.sv
// Bundle of issue, writeback, commit and flush signals between the front end
// and the parametrised reorder buffer. The slave modport is the ROB itself;
// the master modport is the issue/writeback side.
// Optional macro ROB_QUERY_EN adds two combinational operand lookup ports.
interface reorder_buffer_gen_if #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int NUM_WB = 3,
   parameter int XLEN   = 32
);
   logic                     rdy;
   logic                     issue_valid;
   logic                     issue_ready;
   logic [IDX_W-1:0]         issue_tag;
   logic [4:0]               issue_dest;
   logic [1:0]               issue_kind;
   logic                     issue_done;
   logic [XLEN-1:0]          issue_value;
   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*IDX_W-1:0]  wb_tag;
   logic [NUM_WB*XLEN-1:0]   wb_value;
   logic [NUM_WB-1:0]        wb_mispred;
   logic [NUM_WB*XLEN-1:0]   wb_target;
   logic                     commit_valid;
   logic [IDX_W-1:0]         commit_tag;
   logic [4:0]               commit_dest;
   logic [XLEN-1:0]          commit_value;
   logic [1:0]               commit_kind;
   logic                     flush;
   logic [XLEN-1:0]          flush_pc;
   logic [IDX_W:0]           count;
`ifdef ROB_QUERY_EN
   logic [IDX_W-1:0]         q0_tag;
   logic [IDX_W-1:0]         q1_tag;
   logic                     q0_ready;
   logic                     q1_ready;
   logic [XLEN-1:0]          q0_value;
   logic [XLEN-1:0]          q1_value;

   modport master (
      output rdy, issue_valid, issue_dest, issue_kind, issue_done, issue_value,
      output wb_valid, wb_tag, wb_value, wb_mispred, wb_target,
      output q0_tag, q1_tag,
      input  issue_ready, issue_tag, commit_valid, commit_tag, commit_dest,
      input  commit_value, commit_kind, flush, flush_pc, count,
      input  q0_ready, q1_ready, q0_value, q1_value
   );

   modport slave (
      input  rdy, issue_valid, issue_dest, issue_kind, issue_done, issue_value,
      input  wb_valid, wb_tag, wb_value, wb_mispred, wb_target,
      input  q0_tag, q1_tag,
      output issue_ready, issue_tag, commit_valid, commit_tag, commit_dest,
      output commit_value, commit_kind, flush, flush_pc, count,
      output q0_ready, q1_ready, q0_value, q1_value
   );
`else
   modport master (
      output rdy, issue_valid, issue_dest, issue_kind, issue_done, issue_value,
      output wb_valid, wb_tag, wb_value, wb_mispred, wb_target,
      input  issue_ready, issue_tag, commit_valid, commit_tag, commit_dest,
      input  commit_value, commit_kind, flush, flush_pc, count
   );

   modport slave (
      input  rdy, issue_valid, issue_dest, issue_kind, issue_done, issue_value,
      input  wb_valid, wb_tag, wb_value, wb_mispred, wb_target,
      output issue_ready, issue_tag, commit_valid, commit_tag, commit_dest,
      output commit_value, commit_kind, flush, flush_pc, count
   );
`endif
endinterface

// File: rtl/reorder_buffer_gen.sv
// Parametrised in-order-retire reorder buffer. Instructions are allocated at
// the tail, completed out of order by NUM_WB writeback ports, and retired one
// per cycle from the head. Retiring a mispredicted branch squashes the whole
// buffer and pulses flush with the corrected PC.
// Optional macro ROB_QUERY_EN adds two combinational operand lookup ports.
module reorder_buffer_gen #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int NUM_WB = 3,
   parameter int XLEN   = 32
) (
   input logic                 clk,
   input logic                 rst,
   reorder_buffer_gen_if.slave rob
);

   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  done_q;
   logic [DEPTH-1:0]  mispred_q;
   logic [4:0]        dest_q   [DEPTH];
   logic [1:0]        kind_q   [DEPTH];
   logic [XLEN-1:0]   value_q  [DEPTH];
   logic [XLEN-1:0]   target_q [DEPTH];

   logic [IDX_W-1:0]  head_q;
   logic [IDX_W-1:0]  tail_q;
   logic [IDX_W:0]    count_q;
   logic [IDX_W:0]    count_d;

   logic              commitValid_q;
   logic [IDX_W-1:0]  commitTag_q;
   logic [4:0]        commitDest_q;
   logic [XLEN-1:0]   commitValue_q;
   logic [1:0]        commitKind_q;
   logic              flush_q;
   logic [XLEN-1:0]   flushPc_q;

   logic              issueReady;
   logic              commitFire;
   logic              flushNext;
   logic              issueFire;
   logic [IDX_W-1:0]  wbTag [NUM_WB];
   logic [NUM_WB-1:0] wbWrite;

   assign issueReady = (count_q != FULL_COUNT);
   assign commitFire = rob.rdy & (count_q != '0) & done_q[head_q];
   assign flushNext  = commitFire & mispred_q[head_q];
   assign issueFire  = rob.issue_valid & issueReady & rob.rdy & ~flushNext;

   // Pick which writeback ports actually update an entry: the target must be
   // in flight and not yet done, and a lower-numbered port with the same tag wins.
   always_comb begin
      for (int p = 0; p < NUM_WB; p++) begin
         wbTag[p] = rob.wb_tag[p*IDX_W +: IDX_W];
      end
      wbWrite = '0;
      for (int p = 0; p < NUM_WB; p++) begin
         logic shadowed;
         shadowed = 1'b0;
         for (int q = 0; q < p; q++) begin
            if (rob.wb_valid[q] && (wbTag[q] == wbTag[p])) shadowed = 1'b1;
         end
         wbWrite[p] = rob.wb_valid[p] & ~shadowed & valid_q[wbTag[p]] &
                      ~done_q[wbTag[p]] & rob.rdy & ~flushNext;
      end
   end

   // Occupancy moves only when exactly one of issue and commit happens.
   always_comb begin
      count_d = count_q;
      if (issueFire && !commitFire) begin
         count_d = count_q + 1'b1;
      end else if (commitFire && !issueFire) begin
         count_d = count_q - 1'b1;
      end
   end

   // Entry storage and head/tail/count pointers; a retiring mispredict wipes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= '0;
         done_q    <= '0;
         mispred_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i]   <= '0;
            kind_q[i]   <= '0;
            value_q[i]  <= '0;
            target_q[i] <= '0;
         end
      end else if (rob.rdy) begin
         if (flushNext) begin
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
         end else begin
            for (int p = 0; p < NUM_WB; p++) begin
               if (wbWrite[p]) begin
                  done_q[wbTag[p]]    <= 1'b1;
                  value_q[wbTag[p]]   <= rob.wb_value[p*XLEN +: XLEN];
                  mispred_q[wbTag[p]] <= rob.wb_mispred[p];
                  target_q[wbTag[p]]  <= rob.wb_target[p*XLEN +: XLEN];
               end
            end
            if (commitFire) begin
               valid_q[head_q]   <= 1'b0;
               done_q[head_q]    <= 1'b0;
               mispred_q[head_q] <= 1'b0;
               head_q            <= head_q + 1'b1;
            end
            if (issueFire) begin
               valid_q[tail_q]   <= 1'b1;
               done_q[tail_q]    <= rob.issue_done;
               mispred_q[tail_q] <= 1'b0;
               dest_q[tail_q]    <= rob.issue_dest;
               kind_q[tail_q]    <= rob.issue_kind;
               value_q[tail_q]   <= rob.issue_value;
               tail_q            <= tail_q + 1'b1;
            end
            count_q <= count_d;
         end
      end
   end

   // Registered retire/flush outputs: pulses last one cycle, data holds until the next retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commitValid_q <= 1'b0;
         commitTag_q   <= '0;
         commitDest_q  <= '0;
         commitValue_q <= '0;
         commitKind_q  <= '0;
         flush_q       <= 1'b0;
         flushPc_q     <= '0;
      end else begin
         commitValid_q <= commitFire;
         flush_q       <= flushNext;
         if (commitFire) begin
            commitTag_q   <= head_q;
            commitDest_q  <= dest_q[head_q];
            commitValue_q <= value_q[head_q];
            commitKind_q  <= kind_q[head_q];
         end
         if (flushNext) begin
            flushPc_q <= target_q[head_q];
         end
      end
   end

   assign rob.issue_ready  = issueReady;
   assign rob.issue_tag    = tail_q;
   assign rob.count        = count_q;
   assign rob.commit_valid = commitValid_q;
   assign rob.commit_tag   = commitTag_q;
   assign rob.commit_dest  = commitDest_q;
   assign rob.commit_value = commitValue_q;
   assign rob.commit_kind  = commitKind_q;
   assign rob.flush        = flush_q;
   assign rob.flush_pc     = flushPc_q;

`ifdef ROB_QUERY_EN
   // Operand lookup: stored result if complete, else forwarded same-cycle writeback.
   function automatic logic [XLEN:0] lookup(input logic [IDX_W-1:0] tag);
      logic [XLEN:0] r;
      r = {valid_q[tag] & done_q[tag], value_q[tag]};
      if (!r[XLEN]) begin
         for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (rob.wb_valid[p] && (wbTag[p] == tag)) begin
               r = {1'b1, rob.wb_value[p*XLEN +: XLEN]};
            end
         end
      end
      return r;
   endfunction

   // Drive both query ports from the shared lookup.
   always_comb begin
      {rob.q0_ready, rob.q0_value} = lookup(rob.q0_tag);
      {rob.q1_ready, rob.q1_value} = lookup(rob.q1_tag);
   end
`endif

endmodule

// File: tb/tb_reorder_buffer_gen.sv
// Self-checking bench for reorder_buffer_gen: directed table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_reorder_buffer_gen;

   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;
   localparam int NUM_WB = 3;
   localparam int XLEN   = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   reorder_buffer_gen_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .XLEN(XLEN)) bus ();

   reorder_buffer_gen #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .rob (bus.slave)
   );

`ifdef ROB_QUERY_EN
   initial begin
      bus.q0_tag = '0;
      bus.q1_tag = '0;
   end
`endif

   typedef struct packed {
      logic        rdy;
      logic        iv;
      logic [4:0]  dest;
      logic [1:0]  kind;
      logic        idone;
      logic [31:0] ival;
      logic [2:0]  wbv;
      logic [11:0] wbt;
      logic [95:0] wbval;
      logic [2:0]  wbm;
      logic [95:0] wbtgt;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        expCv;
      logic [3:0]  expTag;
      logic [31:0] expVal;
      logic [4:0]  expCount;
   } vec_t;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  dest;
      logic [1:0]  kind;
      logic        done;
      logic        mis;
      logic [31:0] val;
      logic [31:0] tgt;
   } ment_t;

   int checks = 0;
   int errors = 0;

   ment_t       mq[$];
   int          mTail;
   logic        eCv, eFl;
   logic [3:0]  eTag;
   logic [4:0]  eDest;
   logic [1:0]  eKind;
   logic [31:0] eVal, eFpc;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      mq.delete();
      mTail = 0;
      eCv = 0; eFl = 0; eTag = 0; eDest = 0; eKind = 0; eVal = 0; eFpc = 0;
   endfunction

   // One clock edge of the ROB rules: retire the oldest if complete, squash on
   // a mispredicted retire, otherwise apply writebacks and append any new issue.
   function automatic void modelStep(input stim_t s);
      bit commitNow, flushNow;
      int sizeBefore;
      if (!s.rdy) begin
         eCv = 0;
         eFl = 0;
         return;
      end
      sizeBefore = mq.size();
      commitNow  = (sizeBefore > 0) && mq[0].done;
      flushNow   = commitNow && mq[0].mis;
      eCv = commitNow;
      eFl = flushNow;
      if (commitNow) begin
         eTag = mq[0].tag; eDest = mq[0].dest; eKind = mq[0].kind; eVal = mq[0].val;
         if (flushNow) eFpc = mq[0].tgt;
      end
      if (flushNow) begin
         mq.delete();
         mTail = 0;
         return;
      end
      for (int p = 0; p < NUM_WB; p++) begin
         if (s.wbv[p]) begin
            for (int i = 0; i < mq.size(); i++) begin
               if (mq[i].tag == s.wbt[p*4 +: 4] && !mq[i].done) begin
                  mq[i].done = 1;
                  mq[i].val  = s.wbval[p*32 +: 32];
                  mq[i].mis  = s.wbm[p];
                  mq[i].tgt  = s.wbtgt[p*32 +: 32];
               end
            end
         end
      end
      if (commitNow) void'(mq.pop_front());
      if (s.iv && sizeBefore < DEPTH) begin
         ment_t e;
         e.tag = 4'(mTail); e.dest = s.dest; e.kind = s.kind; e.done = s.idone;
         e.mis = 0; e.val = s.ival; e.tgt = 0;
         mq.push_back(e);
         mTail = (mTail + 1) % DEPTH;
      end
   endfunction

   task automatic checkOutput();
      checkVal("issue_ready",  32'(bus.issue_ready), 32'(mq.size() < DEPTH));
      checkVal("issue_tag",    32'(bus.issue_tag), 32'(mTail));
      checkVal("count",        32'(bus.count), 32'(mq.size()));
      checkVal("commit_valid", 32'(bus.commit_valid), 32'(eCv));
      checkVal("commit_tag",   32'(bus.commit_tag), 32'(eTag));
      checkVal("commit_dest",  32'(bus.commit_dest), 32'(eDest));
      checkVal("commit_value", bus.commit_value, eVal);
      checkVal("commit_kind",  32'(bus.commit_kind), 32'(eKind));
      checkVal("flush",        32'(bus.flush), 32'(eFl));
      checkVal("flush_pc",     bus.flush_pc, eFpc);
   endtask

   task automatic drive(input stim_t s);
      bus.rdy         = s.rdy;
      bus.issue_valid = s.iv;
      bus.issue_dest  = s.dest;
      bus.issue_kind  = s.kind;
      bus.issue_done  = s.idone;
      bus.issue_value = s.ival;
      bus.wb_valid    = s.wbv;
      bus.wb_tag      = s.wbt;
      bus.wb_value    = s.wbval;
      bus.wb_mispred  = s.wbm;
      bus.wb_target   = s.wbtgt;
   endtask

   task automatic applyStimulus(input stim_t s);
      drive(s);
      @(posedge clk);
      #1;
      modelStep(s);
      checkOutput();
   endtask

   function automatic stim_t idleStim();
      stim_t s = '0;
      s.rdy = 1;
      return s;
   endfunction

   function automatic stim_t issueStim(input logic [4:0] dest, input logic [1:0] kind,
                                       input logic done, input logic [31:0] val);
      stim_t s = idleStim();
      s.iv = 1; s.dest = dest; s.kind = kind; s.idone = done; s.ival = val;
      return s;
   endfunction

   function automatic stim_t wbStim(input int port, input logic [3:0] tag, input logic [31:0] val,
                                    input logic mis, input logic [31:0] tgt);
      stim_t s = idleStim();
      s.wbv[port] = 1'b1;
      s.wbt[port*4 +: 4] = tag;
      s.wbval[port*32 +: 32] = val;
      s.wbm[port] = mis;
      s.wbtgt[port*32 +: 32] = tgt;
      return s;
   endfunction

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic doReset();
      drive(idleStim());
      rst = 1'b1;
      #2;
      modelReset();
      checkOutput();
      checkVal("reset_count", 32'(bus.count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   vec_t vecs[9];

   initial begin
      bit found;
      stim_t s;

      // Out-of-order completion, in-order retirement: tags 0,1,2 finished as 2,0,1.
      vecs[0] = '{issueStim(5'd1, 2'd0, 1'b0, 32'h0), 1'b0, 4'd0, 32'h0, 5'd1};
      vecs[1] = '{issueStim(5'd2, 2'd0, 1'b0, 32'h0), 1'b0, 4'd0, 32'h0, 5'd2};
      vecs[2] = '{issueStim(5'd3, 2'd0, 1'b0, 32'h0), 1'b0, 4'd0, 32'h0, 5'd3};
      vecs[3] = '{wbStim(0, 4'd2, 32'd7, 1'b0, 32'h0), 1'b0, 4'd0, 32'h0, 5'd3};
      vecs[4] = '{wbStim(1, 4'd0, 32'd5, 1'b0, 32'h0), 1'b0, 4'd0, 32'h0, 5'd3};
      vecs[5] = '{wbStim(2, 4'd1, 32'd6, 1'b0, 32'h0), 1'b1, 4'd0, 32'd5, 5'd2};
      vecs[6] = '{idleStim(),                          1'b1, 4'd1, 32'd6, 5'd1};
      vecs[7] = '{idleStim(),                          1'b1, 4'd2, 32'd7, 5'd0};
      vecs[8] = '{idleStim(),                          1'b0, 4'd0, 32'h0, 5'd0};

      rst = 1'b1;
      drive(idleStim());
      #2;
      modelReset();
      checkOutput();
      checkVal("reset_issue_ready", 32'(bus.issue_ready), 1);
      checkVal("reset_flush_pc", bus.flush_pc, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] fill to full");
      for (int i = 0; i < DEPTH; i++) applyStimulus(issueStim(5'(i), 2'd0, 1'b0, 32'h0));
      checkVal("full_count", 32'(bus.count), 16);
      checkVal("full_ready", 32'(bus.issue_ready), 0);
      applyStimulus(issueStim(5'd31, 2'd0, 1'b0, 32'h0));
      checkVal("overflow_count", 32'(bus.count), 16);
      checkVal("overflow_tag", 32'(bus.issue_tag), 0);

      $display("[TB] full with done head");
      applyStimulus(wbStim(0, 4'd0, 32'h55, 1'b0, 32'h0));
      checkVal("full_wb_count", 32'(bus.count), 16);
      applyStimulus(issueStim(5'd9, 2'd0, 1'b0, 32'h0));
      checkVal("full_commit_valid", 32'(bus.commit_valid), 1);
      checkVal("full_commit_value", bus.commit_value, 32'h55);
      checkVal("full_commit_count", 32'(bus.count), 15);
      applyStimulus(issueStim(5'd9, 2'd0, 1'b0, 32'h0));
      checkVal("refill_count", 32'(bus.count), 16);

      $display("[TB] reset mid-operation");
      doReset();

      $display("[TB] directed table");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].s);
         checkVal($sformatf("vec%0d_commit_valid", i), 32'(bus.commit_valid), 32'(vecs[i].expCv));
         checkVal($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].expCount));
         if (vecs[i].expCv) begin
            checkVal($sformatf("vec%0d_commit_tag", i), 32'(bus.commit_tag), 32'(vecs[i].expTag));
            checkVal($sformatf("vec%0d_commit_value", i), bus.commit_value, vecs[i].expVal);
         end
      end

      $display("[TB] mispredict flush");
      applyStimulus(issueStim(5'd0, 2'd1, 1'b0, 32'h0));
      for (int i = 4; i < 7; i++) applyStimulus(issueStim(5'(i), 2'd0, 1'b0, 32'h0));
      applyStimulus(wbStim(1, 4'd3, 32'h0, 1'b1, 32'h1000));
      s = wbStim(0, 4'd4, 32'h44, 1'b0, 32'h0);
      s.iv = 1; s.dest = 5'd7; s.idone = 1;
      applyStimulus(s);
      checkVal("flush_commit_tag", 32'(bus.commit_tag), 3);
      checkVal("flush_pulse", 32'(bus.flush), 1);
      checkVal("flush_pc_value", bus.flush_pc, 32'h1000);
      checkVal("flush_count", 32'(bus.count), 0);
      applyStimulus(idleStim());
      checkVal("post_flush_pulse", 32'(bus.flush), 0);
      checkVal("post_flush_tag", 32'(bus.issue_tag), 0);
      checkVal("post_flush_count", 32'(bus.count), 0);

      $display("[TB] dual writeback and wraparound");
      for (int i = 0; i < 5; i++) applyStimulus(issueStim(5'(i), 2'd0, 1'b1, 32'(i)));
      applyStimulus(issueStim(5'd5, 2'd0, 1'b0, 32'h0));
      s = idleStim();
      s.wbv = 3'b101;
      s.wbt = {4'd5, 4'd0, 4'd5};
      s.wbval = {32'hB, 32'h0, 32'hA};
      applyStimulus(s);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         applyStimulus(idleStim());
         if (bus.commit_valid && bus.commit_tag == 4'd5) begin
            found = 1;
            checkVal("dual_wb_value", bus.commit_value, 32'hA);
         end
      end
      checkVal("dual_wb_commit_seen", 32'(found), 1);
      for (int i = 0; i < 20; i++) applyStimulus(issueStim(5'(i), 2'd0, 1'b1, 32'h100 + 32'(i)));
      for (int i = 0; i < 3; i++) applyStimulus(idleStim());
      checkVal("wrap_count", 32'(bus.count), 0);
      checkVal("wrap_issue_tag", 32'(bus.issue_tag), 10);
      checkVal("wrap_last_commit_tag", 32'(bus.commit_tag), 9);
      checkVal("wrap_last_commit_value", bus.commit_value, 32'h113);

      $display("[TB] rdy freeze");
      applyStimulus(issueStim(5'd12, 2'd0, 1'b1, 32'h77));
      for (int i = 0; i < 3; i++) begin
         s = issueStim(5'd13, 2'd0, 1'b1, 32'h88);
         s.rdy = 0;
         applyStimulus(s);
         checkVal("freeze_commit_valid", 32'(bus.commit_valid), 0);
         checkVal("freeze_count", 32'(bus.count), 1);
      end
      applyStimulus(idleStim());
      checkVal("resume_commit_valid", 32'(bus.commit_valid), 1);
      checkVal("resume_commit_value", bus.commit_value, 32'h77);
      checkVal("resume_count", 32'(bus.count), 0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 3000; n++) begin
         s = '0;
         s.rdy   = ($urandom_range(0, 9) != 0);
         s.iv    = ($urandom_range(0, 1) != 0);
         s.dest  = 5'($urandom);
         s.kind  = 2'($urandom);
         s.idone = ($urandom_range(0, 9) < 3);
         s.ival  = $urandom;
         for (int p = 0; p < NUM_WB; p++) begin
            if ($urandom_range(0, 9) < 4) begin
               s.wbv[p] = 1'b1;
               if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                  s.wbt[p*4 +: 4] = mq[$urandom_range(0, mq.size() - 1)].tag;
               else
                  s.wbt[p*4 +: 4] = 4'($urandom);
               s.wbval[p*32 +: 32] = $urandom;
               s.wbm[p] = ($urandom_range(0, 99) < 5);
               s.wbtgt[p*32 +: 32] = $urandom;
            end
         end
         applyStimulus(s);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
